fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage in-order core.
- Owns the architectural PC and issues word-aligned requests on the instruction bus.
- Buffers each returned instruction and presents it to the decode stage as a fetch_data_t with valid/ready flow control.
- Accepts a redirect (new PC) that squashes any in-flight or buffered instruction.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC fetched first after reset.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- ireq_valid  out  1  instruction-bus request valid; held until ireq_data_ok
- ireq_addr  out  64  request address; stable while ireq_valid=1
- ireq_data_ok  in  1  response valid this cycle; completes the request
- ireq_data  in  32  instruction word, valid with ireq_data_ok
- out_valid  out  1  out_data holds a live instruction for decode
- out_data  out  192  fetch_data_t {raw_instr, instr{pc, raw_instr}, pcplus4}
- out_ready  in  1  decode accepts out_data this cycle (0 = stall)
- redirect_valid  in  1  squash and restart fetch at redirect_pc
- redirect_pc  in  64  new fetch PC; bits[1:0] forced to 0

Behaviour:
- Reset, the cycle reset=1: ireq_valid=0, out_valid=0, out_data=0, pc=RESET_PC, state=FETCH, kill=0.
- States: FETCH (request outstanding), HOLD (instruction buffered), DRAIN (stale request outstanding).
- FETCH: ireq_valid=1, ireq_addr=pc.
  - ireq_data_ok=1 with no redirect: latch {ireq_data, pc, pc+4} into the output buffer; next state HOLD; out_valid=1 from the next cycle. Latency from ireq_data_ok to out_valid is 1 cycle.
  - ireq_data_ok=1 with redirect_valid=1 in the same cycle: discard the data; pc=redirect_pc; stay in FETCH. The new address is issued the next cycle.
  - redirect_valid=1 with ireq_data_ok=0: pc_pending=redirect_pc; next state DRAIN. The request is not withdrawn, and ireq_addr keeps the old pc.
- DRAIN: ireq_valid=1, ireq_addr=old pc.
  - A further redirect overwrites pc_pending; the latest redirect wins.
  - On ireq_data_ok: discard the data; pc=pc_pending; next state FETCH.
  - out_valid=0 throughout.
- HOLD: out_valid=1; out_data stays stable until accepted; ireq_valid=0.
  - out_ready=1 with no redirect: pc=pc+4; next state FETCH; out_valid=0 the next cycle.
  - redirect_valid=1, regardless of out_ready: drop the buffer; out_valid=0 the next cycle; pc=redirect_pc; next state FETCH. The instruction is not counted as accepted, and decode must not consume it.
  - out_ready=0 with no redirect: stay in HOLD; nothing changes.
- Throughput: at most one instruction per 2 cycles with a zero-wait bus. No speculative prefetch.
- PC arithmetic: 64-bit, wraps modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC + 4 = 0). pcplus4 is computed the same way.
- A redirect with a misaligned PC is aligned by clearing bits[1:0]. No exception is raised.
- Reset asserted mid-transaction, in any state: the outstanding request is abandoned and ireq_valid=0 that cycle. A late ireq_data_ok after reset is ignored only if it arrives in the reset cycle; the bus is reset in the same cycle.
- The redirect priority above applies in every state.

Decomposition:
- pipes package gets:
  - fetch_state_t enum {FETCH, HOLD, DRAIN}
  - PC_RESET constant (default for RESET_PC)
  - reuse of fetch_data_t and instr_data_t
- One sub-module, fetch_pcgen:
  - holds pc and pc_pending
  - computes pc+4, redirect alignment and next-pc selection
- fetch_stage holds the FSM and the output buffer.

Test Plan:
- Reset then zero-wait bus: ireq_addr=0x80000000 in cycle 1; ireq_data_ok with data 0x00000013 → out_valid next cycle with pc=0x80000000, raw_instr=0x13, pcplus4=0x80000004. With out_ready=1, the next ireq_addr is 0x80000004.
- Decode stall: out_ready=0 for 5 cycles in HOLD → out_data constant, ireq_valid=0. out_ready=1 → fetch of pc+4 begins the next cycle.
- Redirect in FETCH with 3-cycle bus latency: redirect_pc=0x80001002 in wait cycle 1 → ireq_addr stays on the old pc until data_ok; data discarded (out_valid never 1); then ireq_addr=0x80001000.
- Two redirects during DRAIN (0x80002000, then 0x80003000) → only 0x80003000 is fetched.
- Redirect in HOLD with out_ready=1 in the same cycle → out_valid=0 next cycle; next ireq_addr=redirect_pc.
- Redirect coincident with ireq_data_ok in FETCH → no out_valid; new address issued the next cycle. Also: wrap test at pc=0xFFFFFFFFFFFFFFFC → pcplus4=0. Reset in DRAIN → ireq_valid=0, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, PC select codes,
// the decode-facing payload structs and the PC alignment helper.
package fetch_stage_pkg;

    localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding, result wanted
        HOLD  = 2'd1,   // instruction buffered for decode
        DRAIN = 2'd2    // request outstanding, result will be thrown away
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_KEEP  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2,
        PC_PEND  = 2'd3
    } pc_sel_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] raw_instr;
    } instr_data_t;

    typedef struct packed {
        logic [31:0] raw_instr;
        instr_data_t instr;
        logic [63:0] pcplus4;
    } fetch_data_t;

    // Redirect targets are forced to a word boundary; misalignment is silently dropped.
    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return pc & ~64'h3;
    endfunction

endpackage

// File: rtl/fetch_stage_pcgen.sv
// PC generator: owns the fetch PC and the pending redirect target used while
// a stale request drains. The FSM in fetch_stage picks the next-PC source.
module fetch_pcgen
    import fetch_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC = PC_RESET
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  pc_sel_t     sel_i,
    input  logic        pend_we_i,
    input  logic [63:0] redirect_pc_i,
    output logic [63:0] pc_o,
    output logic [63:0] pcplus4_o
);

    logic [63:0] pc_q, pc_d;
    logic [63:0] pend_q;
    logic [63:0] redir_al;

    assign redir_al  = align_pc(redirect_pc_i);
    assign pcplus4_o = pc_q + 64'd4;   // wraps modulo 2^64
    assign pc_o      = pc_q;

    // Next-PC selection driven by the fetch FSM.
    always_comb begin
        pc_d = pc_q;
        unique case (sel_i)
            PC_KEEP:  pc_d = pc_q;
            PC_INC:   pc_d = pcplus4_o;
            PC_REDIR: pc_d = redir_al;
            PC_PEND:  pc_d = pend_q;
            default:  pc_d = pc_q;
        endcase
    end

    // PC and pending-target registers; the latest redirect overwrites pend_q.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q   <= RESET_PC;
            pend_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
            if (pend_we_i) pend_q <= redir_al;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues one word request at a time, buffers the
// returned instruction for decode, and handles redirects by either dropping
// the buffer or draining a stale in-flight request.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC = PC_RESET
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        ireq_data_ok,
    input  logic [31:0] ireq_data,
    output logic        out_valid,
    output fetch_data_t out_data,
    input  logic        out_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);

    fetch_state_t state_q, state_d;
    logic         ireq_valid_q;
    logic         out_valid_q;
    fetch_data_t  buf_q;

    pc_sel_t      pc_sel;
    logic         pend_we;
    logic         buf_we;
    logic [63:0]  pc;
    logic [63:0]  pcplus4;

    fetch_pcgen #(.RESET_PC(RESET_PC)) u_pcgen (
        .clk_i         (clk),
        .reset_i       (reset),
        .sel_i         (pc_sel),
        .pend_we_i     (pend_we),
        .redirect_pc_i (redirect_pc),
        .pc_o          (pc),
        .pcplus4_o     (pcplus4)
    );

    // The reset cycle itself must already show an idle bus and empty output,
    // so the registered outputs are masked while reset is high.
    assign ireq_valid = ireq_valid_q & ~reset;
    assign ireq_addr  = pc;
    assign out_valid  = out_valid_q & ~reset;
    assign out_data   = reset ? '0 : buf_q;

    // Next-state and PC-source decode; a redirect always outranks everything else.
    always_comb begin
        state_d = state_q;
        pc_sel  = PC_KEEP;
        pend_we = 1'b0;
        buf_we  = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    if (ireq_data_ok) begin
                        pc_sel = PC_REDIR;          // data dropped, reissue next cycle
                    end else begin
                        pend_we = 1'b1;             // request cannot be withdrawn
                        state_d = DRAIN;
                    end
                end else if (ireq_data_ok) begin
                    buf_we  = 1'b1;
                    state_d = HOLD;
                end
            end
            DRAIN: begin
                if (ireq_data_ok) begin
                    // A redirect landing with the response is newer than pend_q.
                    pc_sel  = redirect_valid ? PC_REDIR : PC_PEND;
                    state_d = FETCH;
                end else if (redirect_valid) begin
                    pend_we = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_sel  = PC_REDIR;
                    state_d = FETCH;
                end else if (out_ready) begin
                    pc_sel  = PC_INC;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // State register with registered bus/decode valids and the output buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            ireq_valid_q <= 1'b1;
            out_valid_q  <= 1'b0;
            buf_q        <= '0;
        end else begin
            state_q      <= state_d;
            ireq_valid_q <= (state_d != HOLD);
            out_valid_q  <= (state_d == HOLD);
            if (buf_we) begin
                buf_q.raw_instr       <= ireq_data;
                buf_q.instr.pc        <= pc;
                buf_q.instr.raw_instr <= ireq_data;
                buf_q.pcplus4         <= pcplus4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a bus model answering from a hashed memory, an
// architectural model of the expected instruction stream (next PC in program
// order, reset by redirects), and a negedge monitor that checks every
// instruction decode accepts plus the handshake rules.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        ireq_data_ok = 1'b0;
    logic [31:0] ireq_data = '0;
    logic        out_valid;
    fetch_data_t out_data;
    logic        out_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .ireq_data_ok   (ireq_data_ok),
        .ireq_data      (ireq_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_acc  = 0;

    logic [63:0] exp_q[$];   // next PC decode should receive
    bit          busy     = 1'b0;
    int          bus_wait = 0;
    int          lat_cfg  = 0;
    bit          lat_rand = 1'b0;

    function automatic logic [31:0] mem(input logic [63:0] a);
        if (a == RPC) return 32'h0000_0013;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus plus the bus response for the current request.
    task automatic apply(input bit rv, input logic [63:0] rpc, input bit rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        if (rv) begin
            exp_q.delete();
            exp_q.push_back(rpc & ~64'h3);
        end
        if (ireq_valid) begin
            if (!busy) begin
                busy     = 1'b1;
                bus_wait = lat_rand ? int'($urandom_range(0, 3)) : lat_cfg;
            end
            if (bus_wait == 0) begin
                ireq_data_ok = 1'b1;
                ireq_data    = mem(ireq_addr);
                busy         = 1'b0;
            end else begin
                ireq_data_ok = 1'b0;
                ireq_data    = $urandom;
                bus_wait--;
            end
        end else begin
            ireq_data_ok = 1'b0;
            busy         = 1'b0;
        end
    endtask

    // Enter reset (from posedge+1), hold two cycles, leave at posedge+2.
    task automatic reset_dut();
        reset = 1'b1;
        #1;
        chk("rst_ireq_valid_now", {191'b0, ireq_valid}, 192'd0);
        busy = 1'b0;
        ireq_data_ok = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        exp_q.push_back(RPC);
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Advance until a fresh request is on the bus; returns before applying inputs.
    task automatic wait_new_req();
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ireq_valid && !busy) return;
            apply(1'b0, '0, 1'b1);
        end
        chk("timeout_new_req", 192'd0, 192'd1);
    endtask

    task automatic wait_hold();
        for (int i = 0; i < 50; i++) begin
            tick();
            if (out_valid) return;
            apply(1'b0, '0, 1'b0);
        end
        chk("timeout_hold", 192'd0, 192'd1);
    endtask

    // Monitor: scoreboard pop on every accepted instruction plus protocol rules.
    bit          p_hold  = 1'b0;
    bit          p_req   = 1'b0;
    bit          p_redir = 1'b0;
    logic [63:0] p_addr  = '0;
    fetch_data_t p_data  = '0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (reset) begin
            chk("rst_ireq_valid", {191'b0, ireq_valid}, 192'd0);
            chk("rst_out_valid", {191'b0, out_valid}, 192'd0);
            chk("rst_out_data", out_data, 192'd0);
            p_hold = 0; p_req = 0; p_redir = 0;
        end else begin
            if (out_valid) chk("hold_no_req", {191'b0, ireq_valid}, 192'd0);
            if (p_hold) begin
                chk("hold_valid", {191'b0, out_valid}, 192'd1);
                chk("hold_stable", out_data, p_data);
            end
            if (p_req) begin
                chk("req_held", {191'b0, ireq_valid}, 192'd1);
                chk("req_addr_stable", {128'b0, ireq_addr}, {128'b0, p_addr});
            end
            if (p_redir) chk("redir_kills_out", {191'b0, out_valid}, 192'd0);
            if (out_valid && out_ready && !redirect_valid) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 192'd0, 192'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("acc_pc", {128'b0, out_data.instr.pc}, {128'b0, e});
                    chk("acc_raw", {160'b0, out_data.raw_instr}, {160'b0, mem(e)});
                    chk("acc_instr_raw", {160'b0, out_data.instr.raw_instr}, {160'b0, mem(e)});
                    chk("acc_pcplus4", {128'b0, out_data.pcplus4}, {128'b0, e + 64'd4});
                    exp_q.push_back(e + 64'd4);
                end
            end
            p_hold  = out_valid && !out_ready && !redirect_valid;
            p_req   = ireq_valid && !ireq_data_ok;
            p_redir = redirect_valid;
            p_addr  = ireq_addr;
            p_data  = out_data;
        end
    end

    initial begin
        logic [63:0] rpc;
        bit rv, rdy;

        // Zero-wait bus: first fetch, 1-cycle latency, 5-cycle decode stall.
        lat_cfg = 0;
        reset_dut();
        chk("first_valid", {191'b0, ireq_valid}, 192'd1);
        chk("first_addr", {128'b0, ireq_addr}, {128'b0, RPC});
        apply(1'b0, '0, 1'b0);
        tick();
        chk("lat1_out_valid", {191'b0, out_valid}, 192'd1);
        chk("first_pc", {128'b0, out_data.instr.pc}, {128'b0, RPC});
        chk("first_raw", {160'b0, out_data.raw_instr}, 192'h13);
        chk("first_pcplus4", {128'b0, out_data.pcplus4}, {128'b0, RPC + 64'd4});
        apply(1'b0, '0, 1'b0);
        repeat (4) begin
            tick();
            apply(1'b0, '0, 1'b0);
        end
        tick();
        apply(1'b0, '0, 1'b1);
        tick();
        chk("next_addr", {128'b0, ireq_addr}, {128'b0, RPC + 64'd4});

        // Redirect in the first wait cycle of a 3-cycle bus.
        lat_cfg = 3;
        apply(1'b1, 64'h8000_1002, 1'b1);
        repeat (3) begin
            tick();
            chk("drain_old_addr", {128'b0, ireq_addr}, {128'b0, RPC + 64'd4});
            apply(1'b0, '0, 1'b1);
        end
        tick();
        chk("redir_aligned_addr", {128'b0, ireq_addr}, 192'h8000_1000);
        apply(1'b0, '0, 1'b1);

        // Two redirects while draining: only the later one is fetched.
        wait_new_req();
        apply(1'b1, 64'h8000_2000, 1'b1);
        tick();
        apply(1'b1, 64'h8000_3000, 1'b1);
        repeat (2) begin
            tick();
            chk("drain2_old_addr", {128'b0, ireq_addr}, 192'h8000_1004);
            apply(1'b0, '0, 1'b1);
        end
        tick();
        chk("latest_redir_wins", {128'b0, ireq_addr}, 192'h8000_3000);
        apply(1'b0, '0, 1'b1);

        // Redirect in HOLD together with out_ready.
        lat_cfg = 1;
        wait_hold();
        apply(1'b1, 64'h8000_4000, 1'b1);
        tick();
        chk("hold_redir_ov", {191'b0, out_valid}, 192'd0);
        chk("hold_redir_addr", {128'b0, ireq_addr}, 192'h8000_4000);
        apply(1'b0, '0, 1'b1);

        // Redirect coincident with the response.
        lat_cfg = 0;
        wait_new_req();
        apply(1'b1, 64'h8000_5000, 1'b1);
        tick();
        chk("coinc_ov", {191'b0, out_valid}, 192'd0);
        chk("coinc_addr", {128'b0, ireq_addr}, 192'h8000_5000);
        apply(1'b0, '0, 1'b1);

        // PC wrap at the top of the address space.
        wait_hold();
        apply(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        wait_hold();
        chk("wrap_pcplus4", {128'b0, out_data.pcplus4}, 192'd0);
        apply(1'b0, '0, 1'b1);
        wait_new_req();
        chk("wrap_addr", {128'b0, ireq_addr}, 192'd0);
        apply(1'b0, '0, 1'b1);

        // Reset while a stale request is draining.
        lat_cfg = 3;
        wait_new_req();
        apply(1'b1, 64'h8000_6000, 1'b1);
        tick();
        reset_dut();
        chk("post_rst_addr", {128'b0, ireq_addr}, {128'b0, RPC});
        apply(1'b0, '0, 1'b1);

        // Randomised traffic: random bus latency, stalls and redirects.
        lat_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            rv  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                default: rpc = {32'h0, 32'h8000_0000 | 32'($urandom_range(0, 4095))};
            endcase
            apply(rv, rpc, rdy);
        end
        tick();
        apply(1'b0, '0, 1'b0);
        tick();
        chk("accepted_some", {191'b0, (n_acc > 100)}, 192'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
